// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
//   PC_ADDR_W      : default address width
//   PC_INSTR_BYTES : default sequential increment in bytes
//   addr_t         : default-width address type
//   pc_sel_e       : next-PC source, listed in priority order
package pc_pkg;

  localparam int PC_ADDR_W      = 32;
  localparam int PC_INSTR_BYTES = 4;

  typedef logic [PC_ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle between the fetch/execute/trap logic and the program-counter unit.
//   master : control side; drives stall/redirect/trap/predecode hints
//   slave  : pc_unit; drives fetch address, next sequential address, flags
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = PC_ADDR_W
);

  logic                     stall_i;
  logic                     redirect_i;
  logic [ADDRESS_WIDTH-1:0] redirect_target_i;
  logic                     trap_i;
  logic [ADDRESS_WIDTH-1:0] trap_vector_i;
  logic                     call_i;
  logic                     ret_i;
  logic [ADDRESS_WIDTH-1:0] address_o;
  logic [ADDRESS_WIDTH-1:0] pc_plus_o;
  logic                     valid_o;
  logic                     misaligned_o;
  logic                     ras_empty_o;
  logic                     ras_full_o;

  modport master (
    output stall_i, redirect_i, redirect_target_i, trap_i, trap_vector_i,
           call_i, ret_i,
    input  address_o, pc_plus_o, valid_o, misaligned_o, ras_empty_o,
           ras_full_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_target_i, trap_i, trap_vector_i,
           call_i, ret_i,
    output address_o, pc_plus_o, valid_o, misaligned_o, ras_empty_o,
           ras_full_o
  );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data as the new top
//   pop       : discard the top (ignored when empty)
//   push+pop  : replace the top in place, count unchanged
//   clear     : drop all entries
//   top       : current top entry (valid when !empty)
//   empty/full: occupancy flags
// A push while full overwrites the oldest entry; count saturates at DEPTH.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    top_ptr;
  logic [PW:0]      count;
  logic             pop_ok;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign top_ptr = wr_ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (pop_ok && push) begin
      // Top replaced in place; pointer and count stay put.
      wr_ptr <= wr_ptr;
      count  <= count;
    end else if (pop_ok) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end
  end

  // NOTE: the entry array has no reset; empty/full come from count, so stale
  // contents are never observed and the array can map onto plain storage.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem[pop_ok ? top_ptr : wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with priority next-PC select and a return-address
// stack for predicting return targets.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pc_unit_if slave port
//              inputs : stall_i, redirect_i/redirect_target_i,
//                       trap_i/trap_vector_i, call_i, ret_i
//              outputs: address_o, pc_plus_o, valid_o, misaligned_o,
//                       ras_empty_o, ras_full_o
// Priority: trap > redirect > stall > predicted return > sequential.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = PC_ADDR_W,
  parameter int                       INSTR_BYTES   = PC_INSTR_BYTES,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                       RAS_DEPTH     = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  // Low address bits that must be zero for an aligned instruction; all-zero
  // when INSTR_BYTES is 1, which also pins misaligned to 0.
  localparam logic [ADDRESS_WIDTH-1:0] LOW_MASK = ADDRESS_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] INC      = ADDRESS_WIDTH'(INSTR_BYTES);

  pc_sel_e                  sel;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     next_mis;
  logic                     valid_q;
  logic                     mis_q;
  logic [ADDRESS_WIDTH-1:0] ras_top;
  logic                     ras_empty;
  logic                     ras_full;
  logic                     ras_push;
  logic                     ras_pop;
  logic                     ras_clear;

  assign pc_plus = pc_q + INC;

  // NOTE: combinational select assigns every output a default first, so no
  // path through the if/case chain can leave a value held (no latches).
  always_comb begin
    sel       = SEL_SEQ;
    next_pc   = pc_plus;
    next_mis  = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;

    if (bus.trap_i)                        sel = SEL_TRAP;
    else if (bus.redirect_i)               sel = SEL_REDIR;
    else if (bus.stall_i)                  sel = SEL_HOLD;
    else if (bus.ret_i && !ras_empty)      sel = SEL_RAS;

    case (sel)
      SEL_TRAP: begin
        next_pc   = bus.trap_vector_i & ~LOW_MASK;
        next_mis  = |(bus.trap_vector_i & LOW_MASK);
        ras_clear = 1'b1;
      end
      SEL_REDIR: begin
        next_pc  = bus.redirect_target_i & ~LOW_MASK;
        next_mis = |(bus.redirect_target_i & LOW_MASK);
      end
      SEL_HOLD: next_pc = pc_q;
      SEL_RAS: begin
        next_pc  = ras_top;
        ras_pop  = 1'b1;
        ras_push = bus.call_i;
      end
      default: ras_push = bus.call_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= next_pc;
      valid_q <= 1'b1;
      mis_q   <= next_mis;
    end
  end

  ras_stack #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.address_o    = pc_q;
  assign bus.pc_plus_o    = pc_plus;
  assign bus.valid_o      = valid_q;
  assign bus.misaligned_o = mis_q;
  assign bus.ras_empty_o  = ras_empty;
  assign bus.ras_full_o   = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a default 32-bit instance and an 8-bit
// instance for the address wrap case.
module tb_pc_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.ADDRESS_WIDTH(32)) bus ();
  pc_unit_if #(.ADDRESS_WIDTH(8))  bus8 ();

  pc_unit #(.ADDRESS_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_unit #(.ADDRESS_WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_i = 0;  bus.redirect_i = 0; bus.redirect_target_i = '0;
    bus.trap_i = 0;   bus.trap_vector_i = '0; bus.call_i = 0; bus.ret_i = 0;
    bus8.stall_i = 0; bus8.redirect_i = 0; bus8.redirect_target_i = '0;
    bus8.trap_i = 0;  bus8.trap_vector_i = '0; bus8.call_i = 0; bus8.ret_i = 0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_i = 1; bus.redirect_target_i = target;
    step();
    bus.redirect_i = 0;
  endtask

  initial begin
    idle();

    // Reset state
    rst = 1;
    step(); step();
    check("rst_addr", bus.address_o, 32'h0);
    check("rst_plus", bus.pc_plus_o, 32'h4);
    check("rst_valid", {31'b0, bus.valid_o}, 32'h0);
    check("rst_mis", {31'b0, bus.misaligned_o}, 32'h0);
    check("rst_empty", {31'b0, bus.ras_empty_o}, 32'h1);
    check("rst_full", {31'b0, bus.ras_full_o}, 32'h0);

    // Free-running sequence
    rst = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("seq_addr", bus.address_o, 32'(4 * i));
      check("seq_valid", {31'b0, bus.valid_o}, 32'h1);
    end

    // Stall holds PC; a call under stall does not push
    redirect(32'h10);
    check("redir_10", bus.address_o, 32'h10);
    bus.stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      bus.call_i = (i == 1);
      step();
      check("stall_addr", bus.address_o, 32'h10);
      check("stall_plus", bus.pc_plus_o, 32'h14);
      check("stall_empty", {31'b0, bus.ras_empty_o}, 32'h1);
    end
    idle();
    step();
    check("after_stall", bus.address_o, 32'h14);

    // Call / predicted return / return on empty stack
    redirect(32'h20);
    bus.call_i = 1;
    step();
    bus.call_i = 0;
    check("call_addr", bus.address_o, 32'h24);
    check("call_nonempty", {31'b0, bus.ras_empty_o}, 32'h0);
    redirect(32'h200);
    check("at_200", bus.address_o, 32'h200);
    bus.ret_i = 1;
    step();
    bus.ret_i = 0;
    check("ret_pred", bus.address_o, 32'h24);
    check("ret_empty", {31'b0, bus.ras_empty_o}, 32'h1);
    redirect(32'h204);
    bus.ret_i = 1;
    step();
    bus.ret_i = 0;
    check("ret_on_empty", bus.address_o, 32'h208);
    check("ret_on_empty_e", {31'b0, bus.ras_empty_o}, 32'h1);

    // Five calls into a 4-deep stack, then five returns
    redirect(32'h0);
    for (int k = 0; k < 5; k++) begin
      bus.call_i = 1;
      step();
      bus.call_i = 0;
      check("ncall_addr", bus.address_o, 32'(16 * k + 4));
      check("ncall_full", {31'b0, bus.ras_full_o}, (k >= 3) ? 32'h1 : 32'h0);
      redirect(32'(16 * (k + 1)));
    end
    bus.ret_i = 1;
    step(); check("nret_0", bus.address_o, 32'h44);
    check("nret_notfull", {31'b0, bus.ras_full_o}, 32'h0);
    step(); check("nret_1", bus.address_o, 32'h34);
    step(); check("nret_2", bus.address_o, 32'h24);
    step(); check("nret_3", bus.address_o, 32'h14);
    check("nret_empty", {31'b0, bus.ras_empty_o}, 32'h1);
    step(); check("nret_seq", bus.address_o, 32'h18);

    // Simultaneous call+ret replaces the top entry
    bus.ret_i = 0; bus.call_i = 1;
    step();
    check("cr_call", bus.address_o, 32'h1C);
    bus.ret_i = 1;
    step();
    check("cr_pop", bus.address_o, 32'h1C);
    check("cr_nonempty", {31'b0, bus.ras_empty_o}, 32'h0);
    bus.call_i = 0;
    step();
    check("cr_replaced", bus.address_o, 32'h20);
    check("cr_empty", {31'b0, bus.ras_empty_o}, 32'h1);
    bus.ret_i = 0;

    // Trap beats redirect and clears the stack; misaligned redirect
    bus.call_i = 1;
    step();
    bus.call_i = 0;
    check("pre_trap_fill", {31'b0, bus.ras_empty_o}, 32'h0);
    bus.trap_i = 1; bus.trap_vector_i = 32'h100;
    bus.redirect_i = 1; bus.redirect_target_i = 32'h300;
    step();
    idle();
    check("trap_addr", bus.address_o, 32'h100);
    check("trap_clear", {31'b0, bus.ras_empty_o}, 32'h1);
    check("trap_mis", {31'b0, bus.misaligned_o}, 32'h0);
    redirect(32'h303);
    check("mis_addr", bus.address_o, 32'h300);
    check("mis_flag", {31'b0, bus.misaligned_o}, 32'h1);
    step();
    check("mis_drop", {31'b0, bus.misaligned_o}, 32'h0);
    check("mis_next", bus.address_o, 32'h304);

    // Reset during a call discards the push
    bus.call_i = 1;
    step();
    check("prerst_fill", {31'b0, bus.ras_empty_o}, 32'h0);
    rst = 1;
    step();
    check("midrst_addr", bus.address_o, 32'h0);
    check("midrst_empty", {31'b0, bus.ras_empty_o}, 32'h1);
    check("midrst_valid", {31'b0, bus.valid_o}, 32'h0);
    rst = 0; bus.call_i = 0;
    step();
    check("postrst_addr", bus.address_o, 32'h4);
    check("postrst_empty", {31'b0, bus.ras_empty_o}, 32'h1);

    // 8-bit instance wraps at 0xFC
    bus8.redirect_i = 1; bus8.redirect_target_i = 8'hFC;
    step();
    bus8.redirect_i = 0;
    check("w8_addr", {24'b0, bus8.address_o}, 32'hFC);
    check("w8_plus", {24'b0, bus8.pc_plus_o}, 32'h00);
    step();
    check("w8_wrap", {24'b0, bus8.address_o}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
